// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode and select encodings for the multicycle MIPS control unit
// Optional macro OVERFLOW_TRAP_EN adds the EXCEPT state.
package mips_ctrl_pkg;
   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
      S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JUMP, S_HALT
`ifdef OVERFLOW_TRAP_EN
      , S_EXCEPT
`endif
   } state_t;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] FN_BREAK = 6'h0d;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [2:0] ALUOP_ADD   = 3'b000;
   localparam logic [2:0] ALUOP_SUB   = 3'b001;
   localparam logic [2:0] ALUOP_FUNCT = 3'b010;
   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_EXC    = 2'b11;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: 3-bit load/decrement wait counter, o_last high when the count reaches zero
// Ports: clk, i_rst_n (async active-low), i_load (load LOAD_VAL), o_last (count == 0)
module mem_wait_timer #(
   parameter logic [2:0] LOAD_VAL = 3'd1
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_last
);
   logic [2:0] r_cnt;
   always_ff @(posedge clk or negedge i_rst_n)
      if (!i_rst_n) r_cnt <= 3'd0;
      else if (i_load) r_cnt <= LOAD_VAL;
      else if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
   assign o_last = (r_cnt == 3'd0);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM of the multicycle MIPS datapath
// Inputs: clk, reset (async active-low), Opcode/Funct (IR fields), Zero, Overflow (ALU flags)
// Outputs: datapath enables/selects PCWrite..PCSource, EPCWrite, Halted
// Macro OVERFLOW_TRAP_EN: signed-overflow trap through the EXCEPT state.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       Overflow,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MDRWrite,
   output logic       RegDst,
   output logic       MemToReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic [1:0] PCSource,
   output logic       EPCWrite,
   output logic       Halted
);
   state_t r_state, w_next, w_wb_next;
   logic w_last, w_load, w_trap;
   // the timer reloads only when a waiting state is entered, not while it repeats
   assign w_load = (w_next == S_FETCH || w_next == S_MEM_READ) && w_next != r_state;
   mem_wait_timer #(.LOAD_VAL(3'(MEM_WAIT_CYCLES))) u_timer (
      .clk(clk), .i_rst_n(reset), .i_load(w_load), .o_last(w_last)
   );
`ifdef OVERFLOW_TRAP_EN
   logic r_ovf;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_ovf <= 1'b0;
      else if (w_next == S_FETCH && r_state != S_FETCH) r_ovf <= 1'b0;
      else if (r_state == S_EXEC_R || r_state == S_EXEC_I) r_ovf <= Overflow;
   // only signed add/sub/addi trap; unsigned forms write back regardless
   assign w_trap = r_ovf && ((r_state == S_R_WB && (Funct == FN_ADD || Funct == FN_SUB)) ||
                             (r_state == S_I_WB && Opcode == OP_ADDI));
   assign w_wb_next = w_trap ? S_EXCEPT : S_FETCH;
`else
   logic w_unused;
   assign w_unused = Overflow;
   assign w_trap = 1'b0;
   assign w_wb_next = S_FETCH;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= S_RESET;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      PCWrite = 1'b0; IorD = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; MDRWrite = 1'b0;
      RegDst = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = SRCB_B;
      ALUOp = ALUOP_ADD; PCSource = PCSRC_ALU; EPCWrite = 1'b0; Halted = 1'b0;
      case (r_state)
         S_RESET: w_next = S_FETCH;
         S_FETCH: begin
            ALUSrcB = SRCB_FOUR;
            IRWrite = w_last;
            PCWrite = w_last;
            w_next = w_last ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            case (Opcode)
               OP_RTYPE:          w_next = (Funct == FN_BREAK) ? S_HALT : S_EXEC_R;
               OP_LW, OP_SW:      w_next = S_MEM_ADDR;
               OP_BEQ, OP_BNE:    w_next = S_BRANCH;
               OP_J:              w_next = S_JUMP;
               OP_ADDI, OP_ADDIU: w_next = S_EXEC_I;
               default:           w_next = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp = ALUOP_FUNCT;
            w_next = S_R_WB;
         end
         S_R_WB: begin
            RegDst = 1'b1;
            RegWrite = !w_trap;
            w_next = w_wb_next;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            w_next = S_I_WB;
         end
         S_I_WB: begin
            RegWrite = !w_trap;
            w_next = w_wb_next;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            w_next = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            IorD = 1'b1;
            MDRWrite = w_last;
            w_next = w_last ? S_MEM_WB : S_MEM_READ;
         end
         S_MEM_WB: begin
            MemToReg = 1'b1;
            RegWrite = 1'b1;
            w_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            IorD = 1'b1;
            MemWrite = 1'b1;
            w_next = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp = ALUOP_SUB;
            PCSource = PCSRC_ALUOUT;
            PCWrite = (Opcode == OP_BEQ) ? Zero : !Zero;
            w_next = S_FETCH;
         end
         S_JUMP: begin
            PCSource = PCSRC_JUMP;
            PCWrite = 1'b1;
            w_next = S_FETCH;
         end
         S_HALT: Halted = 1'b1;
`ifdef OVERFLOW_TRAP_EN
         S_EXCEPT: begin
            EPCWrite = 1'b1;
            PCSource = PCSRC_EXC;
            PCWrite = 1'b1;
            w_next = S_FETCH;
         end
`endif
         default: w_next = S_RESET;
      endcase
   end
endmodule
